frogg_mover: RTL
================

FROGG_MOVER -- requirements
Module: frogg_mover

Interface
REQ-001 The block SHALL have parameter c_POS_W, default 6, giving the width of all position and count buses.
REQ-002 The block SHALL have parameter c_GAME_WIDTH, default 40, giving the playfield width in tiles.
REQ-003 The block SHALL have parameter c_GAME_HEIGHT, default 30, giving the playfield height in tiles.
REQ-004 The block SHALL have parameter c_SPRITE_W, default 1, giving the sprite width in tiles.
REQ-005 The block SHALL have parameter c_SPRITE_H, default 1, giving the sprite height in tiles.
REQ-006 The block SHALL have parameters c_START_X, default (c_GAME_WIDTH-c_SPRITE_W)/2, and c_START_Y, default c_GAME_HEIGHT-c_SPRITE_H, giving the spawn tile.
REQ-007 The block SHALL have parameter c_FIRST_DELAY, default 12500000, giving the cycles from the first hop to the first auto-repeat hop.
REQ-008 The block SHALL have parameter c_REPEAT_DELAY, default 2550000, giving the cycles between later auto-repeat hops.
REQ-009 The block SHALL have ports, clock and reset first:
 - i_Clk  in  1  system clock
 - i_Rst  in  1  asynchronous reset, active-high
 - i_Col_Count_Div  in  c_POS_W  current tile column
 - i_Row_Count_Div  in  c_POS_W  current tile row
 - i_Up, i_Dn, i_Lt, i_Rt  in  1 each  direction buttons, already debounced
 - i_Enable  in  1  movement permitted
 - i_Respawn  in  1  one-cycle request to return to spawn
 - o_X, o_Y  out  c_POS_W each  sprite top-left tile
 - o_Dir  out  2  last hop direction: 0 up, 1 down, 2 left, 3 right
 - o_Hop  out  1  one-cycle pulse on every position change caused by a hop
 - o_Draw  out  1  sprite covers the current tile

Function
REQ-010 A press SHALL be valid only when exactly one of the four buttons is high; zero or two or more high buttons SHALL be invalid.
REQ-011 The FSM SHALL have the states IDLE, FIRST and REPEAT.
REQ-012 In IDLE, a valid press with i_Enable high SHALL cause a hop on the next clock edge and a transition to FIRST, with the delay counter cleared.
REQ-013 In FIRST, the block SHALL hop again when the counter reaches c_FIRST_DELAY-1 with the same button still valid, then SHALL move to REPEAT and clear the counter.
REQ-014 In REPEAT, the block SHALL hop every c_REPEAT_DELAY cycles while the same button stays valid.
REQ-015 In FIRST or REPEAT, release of the button, a different or invalid button pattern, or i_Enable low SHALL return the FSM to IDLE on the next edge with no hop.
REQ-016 A hop SHALL update one axis by exactly 1 tile, update o_Dir and pulse o_Hop.
REQ-017 Hops SHALL be clamped so that X stays in 0..c_GAME_WIDTH-c_SPRITE_W and Y stays in 0..c_GAME_HEIGHT-c_SPRITE_H.
REQ-018 A hop blocked by the clamp SHALL leave the position unchanged, SHALL still update o_Dir, SHALL keep o_Hop low, and SHALL still advance the FSM.
REQ-019 i_Respawn SHALL take priority over any hop in the same cycle: it SHALL load c_START_X and c_START_Y on the next edge, force IDLE, keep o_Hop low, and leave o_Dir unchanged.
REQ-020 The delay counter SHALL be at least clog2(max(c_FIRST_DELAY, c_REPEAT_DELAY)) bits wide and SHALL never wrap.
REQ-021 o_Draw SHALL be registered with 1-cycle latency.
REQ-022 o_Draw SHALL be high when o_X <= col < o_X+c_SPRITE_W and o_Y <= row < o_Y+c_SPRITE_H.
REQ-023 The comparisons for o_Draw SHALL be computed at c_POS_W+1 bits so that the sum does not overflow.
REQ-024 o_Draw SHALL always use the position that was current in the cycle before.

Reset
REQ-025 Asserting i_Rst SHALL immediately set: o_X=c_START_X, o_Y=c_START_Y, o_Dir=0, o_Hop=0, o_Draw=0, FSM=IDLE and counter=0.
REQ-026 Reset asserted mid-hold SHALL abort the repeat, and the first edge after release SHALL act as IDLE.
REQ-027 The block SHALL use no initial blocks for functional state.

Structure
REQ-028 A shared package frogg_pkg SHALL hold the direction encodings, the FSM state encodings and the default tile-grid constants.
REQ-029 A sub-module frogg_sprite_hit SHALL hold the registered rectangle comparison of REQ-022.
REQ-030 The hop FSM and the counter SHALL stay in frogg_mover.

Verification
REQ-031 The bench SHALL cover these directed scenarios, using c_FIRST_DELAY=8, c_REPEAT_DELAY=4, a 40x30 field, a 1x1 sprite and spawn (19,29):
 - Reset release, then i_Up held 1 cycle -> o_Y=28, o_Dir=0, o_Hop pulses once, FSM back to IDLE.
 - i_Rt held 20 cycles -> hops at cycles 1, 9, 13 and 17, so o_X=23, with exactly 4 o_Hop pulses.
 - At X=39 with i_Rt held -> o_X stays 39, o_Dir=3, o_Hop stays low, FSM still cycles through its states.
 - i_Up and i_Lt high together -> no movement; i_Up alone 3 cycles later -> one hop.
 - i_Respawn in the same cycle as a hop edge at (5,5) -> (19,29), no o_Hop, FSM=IDLE.
 - Sprite 3x2 at (0,0), row 1 col 2 presented -> o_Draw=1 one cycle later; col 3 -> 0; col 63 with c_POS_W=6 -> 0 with no overflow.

Source files
------------

// File: rtl/frogg_pkg.sv
// Shared encodings and default tile-grid constants for the frog sprite mover.
package frogg_pkg;

    typedef enum logic [1:0] {
        DIR_UP = 2'd0,
        DIR_DN = 2'd1,
        DIR_LT = 2'd2,
        DIR_RT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam int c_DEF_POS_W       = 6;
    localparam int c_DEF_GAME_WIDTH  = 40;
    localparam int c_DEF_GAME_HEIGHT = 30;
    localparam int c_DEF_SPRITE_W    = 1;
    localparam int c_DEF_SPRITE_H    = 1;

    // Counter only ever holds 0..max-1, so clog2(max) bits are enough.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/frogg_sprite_hit.sv
// Registered test of whether the current tile lies inside the sprite rectangle.
module frogg_sprite_hit #(
    parameter int c_POS_W    = 6,
    parameter int c_SPRITE_W = 1,
    parameter int c_SPRITE_H = 1
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [c_POS_W-1:0] i_Col,
    input  logic [c_POS_W-1:0] i_Row,
    input  logic [c_POS_W-1:0] i_X,
    input  logic [c_POS_W-1:0] i_Y,
    output logic               o_Hit
);

    // One extra bit so x+width cannot wrap back into the field.
    logic [c_POS_W:0] col_w, row_w, x_lo, y_lo, x_hi, y_hi;
    logic             hit_d;

    assign col_w = {1'b0, i_Col};
    assign row_w = {1'b0, i_Row};
    assign x_lo  = {1'b0, i_X};
    assign y_lo  = {1'b0, i_Y};
    assign x_hi  = x_lo + (c_POS_W+1)'(c_SPRITE_W);
    assign y_hi  = y_lo + (c_POS_W+1)'(c_SPRITE_H);
    assign hit_d = (col_w >= x_lo) && (col_w < x_hi) &&
                   (row_w >= y_lo) && (row_w < y_hi);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Hit <= 1'b0;
        end else begin
            o_Hit <= hit_d;
        end
    end

endmodule

// File: rtl/frogg_mover.sv
// Button-driven frog sprite: one hop per press, then delayed auto-repeat while held,
// clamped to the playfield, with a respawn override and a registered draw flag.
module frogg_mover
    import frogg_pkg::*;
#(
    parameter int c_POS_W        = c_DEF_POS_W,
    parameter int c_GAME_WIDTH   = c_DEF_GAME_WIDTH,
    parameter int c_GAME_HEIGHT  = c_DEF_GAME_HEIGHT,
    parameter int c_SPRITE_W     = c_DEF_SPRITE_W,
    parameter int c_SPRITE_H     = c_DEF_SPRITE_H,
    parameter int c_START_X      = (c_GAME_WIDTH - c_SPRITE_W) / 2,
    parameter int c_START_Y      = c_GAME_HEIGHT - c_SPRITE_H,
    parameter int c_FIRST_DELAY  = 12500000,
    parameter int c_REPEAT_DELAY = 2550000
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [c_POS_W-1:0] i_Col_Count_Div,
    input  logic [c_POS_W-1:0] i_Row_Count_Div,
    input  logic               i_Up,
    input  logic               i_Dn,
    input  logic               i_Lt,
    input  logic               i_Rt,
    input  logic               i_Enable,
    input  logic               i_Respawn,
    output logic [c_POS_W-1:0] o_X,
    output logic [c_POS_W-1:0] o_Y,
    output logic [1:0]         o_Dir,
    output logic               o_Hop,
    output logic               o_Draw
);

    localparam int c_CNT_W = cnt_width(c_FIRST_DELAY, c_REPEAT_DELAY);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_FIRST_LAST = c_CNT_W'(c_FIRST_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_REP_LAST   = c_CNT_W'(c_REPEAT_DELAY - 1);
    localparam logic [c_POS_W-1:0] c_POS_ONE    = c_POS_W'(1);
    localparam logic [c_POS_W-1:0] c_X_MAX      = c_POS_W'(c_GAME_WIDTH - c_SPRITE_W);
    localparam logic [c_POS_W-1:0] c_Y_MAX      = c_POS_W'(c_GAME_HEIGHT - c_SPRITE_H);
    localparam logic [c_POS_W-1:0] c_X0         = c_POS_W'(c_START_X);
    localparam logic [c_POS_W-1:0] c_Y0         = c_POS_W'(c_START_Y);

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [c_POS_W-1:0]   x_q, x_d, y_q, y_d;
    dir_t                 dir_q, dir_d, press_dir;
    logic                 hop_q, hop_d;
    logic                 press_valid, press_ok, hold_ok, do_hop;

    always_comb begin
        press_valid = 1'b1;
        press_dir   = DIR_UP;
        case ({i_Up, i_Dn, i_Lt, i_Rt})
            4'b1000: press_dir = DIR_UP;
            4'b0100: press_dir = DIR_DN;
            4'b0010: press_dir = DIR_LT;
            4'b0001: press_dir = DIR_RT;
            default: press_valid = 1'b0;
        endcase
    end

    // While held, o_Dir always equals the held button, so it doubles as the hold reference.
    assign press_ok = press_valid && i_Enable;
    assign hold_ok  = press_ok && (press_dir == dir_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        hop_d   = 1'b0;
        do_hop  = 1'b0;

        case (state_q)
            IDLE: begin
                if (press_ok) begin
                    do_hop  = 1'b1;
                    state_d = FIRST;
                    cnt_d   = '0;
                end
            end
            FIRST: begin
                if (!hold_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_FIRST_LAST) begin
                    do_hop  = 1'b1;
                    state_d = REPEAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            REPEAT: begin
                if (!hold_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_REP_LAST) begin
                    do_hop = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A hop stopped by the edge still turns the frog but does not pulse o_Hop.
        if (do_hop) begin
            dir_d = press_dir;
            case (press_dir)
                DIR_UP: if (y_q != '0)     begin y_d = y_q - c_POS_ONE; hop_d = 1'b1; end
                DIR_DN: if (y_q < c_Y_MAX) begin y_d = y_q + c_POS_ONE; hop_d = 1'b1; end
                DIR_LT: if (x_q != '0)     begin x_d = x_q - c_POS_ONE; hop_d = 1'b1; end
                DIR_RT: if (x_q < c_X_MAX) begin x_d = x_q + c_POS_ONE; hop_d = 1'b1; end
                default: ;
            endcase
        end

        if (i_Respawn) begin
            state_d = IDLE;
            cnt_d   = '0;
            x_d     = c_X0;
            y_d     = c_Y0;
            dir_d   = dir_q;
            hop_d   = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= c_X0;
            y_q     <= c_Y0;
            dir_q   <= DIR_UP;
            hop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            hop_q   <= hop_d;
        end
    end

    frogg_sprite_hit #(
        .c_POS_W   (c_POS_W),
        .c_SPRITE_W(c_SPRITE_W),
        .c_SPRITE_H(c_SPRITE_H)
    ) u_hit (
        .i_Clk(i_Clk),
        .i_Rst(i_Rst),
        .i_Col(i_Col_Count_Div),
        .i_Row(i_Row_Count_Div),
        .i_X  (x_q),
        .i_Y  (y_q),
        .o_Hit(o_Draw)
    );

    assign o_X   = x_q;
    assign o_Y   = y_q;
    assign o_Dir = dir_q;
    assign o_Hop = hop_q;

endmodule
